// File: rtl/pop_counter_bank_pkg.sv
// Shared FSM encoding and count helpers for the pop counter bank.
// Optional saturation is enabled with POPCNT_SATURATE_EN.
package pop_counter_pkg;

  localparam logic [0:0] S_READY = 1'b0;
  localparam logic [0:0] S_PEND  = 1'b1;

  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pop_counter_bank_if.sv
// Readout request/valid bus of the pop counter bank.
// Master issues req/idx, slave returns cuenta/valid.
interface pop_counter_bank_if #(
  parameter int INDEX = 2,
  parameter int CNT_W = 5
);

  logic             req;
  logic [INDEX-1:0] idx;
  logic [CNT_W-1:0] cuenta;
  logic             valid;

  modport master (
    output req,
    output idx,
    input  cuenta,
    input  valid
  );

  modport slave (
    input  req,
    input  idx,
    output cuenta,
    output valid
  );

endinterface

// File: rtl/pop_counter_bank_chan.sv
// Single pop counter channel; wraps by default,
// saturates with sticky ovf under POPCNT_SATURATE_EN.
module pop_counter_chan
  import pop_counter_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] count_q, count_d;

`ifdef POPCNT_SATURATE_EN
  localparam logic [CNT_W-1:0] MAX =
    CNT_W'(cnt_max(CNT_W));

  logic ovf_q, ovf_d;

  // Increment until full, then hold and flag.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pop) begin
      if (count_q == MAX) ovf_d = 1'b1;
      else count_d = count_q + 1'b1;
    end
  end

  // Count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Free-running modulo counter.
  always_comb begin
    count_d = pop ? count_q + 1'b1 : count_q;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end

  assign ovf = 1'b0;
`endif

  assign count = count_q;

endmodule

// File: rtl/pop_counter_bank.sv
// Per-FIFO pop counter bank with deferred, registered readout.
// Build option: POPCNT_SATURATE_EN selects saturating counters.
module pop_counter_bank
  import pop_counter_pkg::*;
#(
  parameter int FIFO_UNITS = 4,
  parameter int INDEX      = 2,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  pop_counter_bank_if.slave     bus,
  input  logic                  IDLE,
  input  logic [FIFO_UNITS-1:0] pop,
  output logic [FIFO_UNITS-1:0] ovf
);

  logic [CNT_W-1:0] cnt [FIFO_UNITS];

  for (genvar g = 0; g < FIFO_UNITS; g++) begin : g_chan
    pop_counter_chan #(.CNT_W(CNT_W)) u_chan (
      .clk   (clk),
      .reset (reset),
      .pop   (pop[g]),
      .count (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  logic [0:0]       state_q, state_d;
  logic [INDEX-1:0] pend_q, pend_d;
  logic [INDEX-1:0] sel;
  logic             serve;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic             valid_q;

  // Readout FSM: serve now when idle, else park one request.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    serve   = 1'b0;
    sel     = bus.idx;
    unique case (state_q)
      S_READY: begin
        if (bus.req) begin
          if (IDLE) begin
            serve = 1'b1;
          end else begin
            state_d = S_PEND;
            pend_d  = bus.idx;
          end
        end
      end
      S_PEND: begin
        sel = pend_q;
        if (IDLE) begin
          serve   = 1'b1;
          state_d = S_READY;
        end
      end
    endcase
  end

  // Read mux; out-of-range channels read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      if (sel == INDEX'(i)) rd_cnt = cnt[i];
    end
    cuenta_d = serve ? rd_cnt : cuenta_q;
  end

  // FSM state, pending index and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_READY;
      pend_q   <= '0;
      cuenta_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cuenta_q <= cuenta_d;
      valid_q  <= serve;
    end
  end

  assign bus.cuenta = cuenta_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_pop_counter_bank.sv
// Directed bench: 4-, 8- and 3-channel instances.
// Expected values derive from POPCNT_SATURATE_EN.
module tb_pop_counter_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pop_counter_bank_if #(.INDEX(2), .CNT_W(5)) b4 ();
  logic       idle4;
  logic [3:0] pop4;
  logic [3:0] ovf4;

  pop_counter_bank #(.FIFO_UNITS(4), .INDEX(2), .CNT_W(5)) u4 (
    .clk(clk), .reset(reset), .bus(b4),
    .IDLE(idle4), .pop(pop4), .ovf(ovf4)
  );

  pop_counter_bank_if #(.INDEX(3), .CNT_W(8)) b8 ();
  logic       idle8;
  logic [7:0] pop8;
  logic [7:0] ovf8;

  pop_counter_bank #(.FIFO_UNITS(8), .INDEX(3), .CNT_W(8)) u8 (
    .clk(clk), .reset(reset), .bus(b8),
    .IDLE(idle8), .pop(pop8), .ovf(ovf8)
  );

  pop_counter_bank_if #(.INDEX(2), .CNT_W(4)) b3 ();
  logic       idle3;
  logic [2:0] pop3;
  logic [2:0] ovf3;

  pop_counter_bank #(.FIFO_UNITS(3), .INDEX(2), .CNT_W(4)) u3 (
    .clk(clk), .reset(reset), .bus(b3),
    .IDLE(idle3), .pop(pop3), .ovf(ovf3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] pop;
    logic       req;
    logic [1:0] idx;
    logic       idle;
    logic       ev;
    logic [4:0] ec;
  } vec_t;

  vec_t tv [32];
  int   nv = 0;

  task automatic add(input logic [3:0] p, input logic r,
                     input logic [1:0] x, input logic il,
                     input logic v, input logic [4:0] c);
    tv[nv] = '{p, r, x, il, v, c};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd4(input int x, input int exp, input string nm);
    b4.req = 1'b1;
    b4.idx = 2'(x);
    idle4  = 1'b1;
    tick();
    chk({nm, ".valid"}, int'(b4.valid), 1);
    chk({nm, ".cuenta"}, int'(b4.cuenta), exp);
    b4.req = 1'b0;
  endtask

  int exp_wrap;
  int exp_ovf;

  initial begin
`ifdef POPCNT_SATURATE_EN
    exp_wrap = 31;
    exp_ovf  = 8;
`else
    exp_wrap = 1;
    exp_ovf  = 0;
`endif
    reset = 1'b1;
    b4.req = 1'b0; b4.idx = '0; idle4 = 1'b1; pop4 = '0;
    b8.req = 1'b0; b8.idx = '0; idle8 = 1'b1; pop8 = '0;
    b3.req = 1'b0; b3.idx = '0; idle3 = 1'b1; pop3 = '0;
    #1;
    tick();
    tick();
    chk("rst.valid", int'(b4.valid), 0);
    chk("rst.cuenta", int'(b4.cuenta), 0);
    chk("rst.ovf", int'(ovf4), 0);
    chk("rst8.valid", int'(b8.valid), 0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) add(4'b0101, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0100, 0, 0, 1, 0, 0);
    add(4'b0000, 1, 2, 1, 1, 7);
    add(4'b0000, 0, 0, 1, 0, 7);
    for (int i = 0; i < 4; i++) add(4'b0010, 0, 0, 1, 0, 7);
    add(4'b0000, 1, 1, 0, 0, 7);
    add(4'b0000, 0, 0, 0, 0, 7);
    add(4'b0000, 1, 3, 0, 0, 7);
    add(4'b0000, 0, 0, 0, 0, 7);
    add(4'b0000, 0, 0, 0, 0, 7);
    add(4'b0000, 0, 0, 1, 1, 4);
    add(4'b0000, 0, 0, 1, 0, 4);
    add(4'b0001, 0, 0, 1, 0, 4);
    add(4'b0001, 0, 0, 1, 0, 4);
    add(4'b0001, 1, 0, 1, 1, 5);
    add(4'b0000, 1, 0, 1, 1, 6);
    add(4'b0000, 0, 0, 1, 0, 6);

    for (int i = 0; i < nv; i++) begin
      pop4   = tv[i].pop;
      b4.req = tv[i].req;
      b4.idx = tv[i].idx;
      idle4  = tv[i].idle;
      tick();
      chk($sformatf("v%0d.valid", i), int'(b4.valid), int'(tv[i].ev));
      chk($sformatf("v%0d.cuenta", i), int'(b4.cuenta), int'(tv[i].ec));
    end
    chk("tbl.ovf", int'(ovf4), 0);

    pop4 = 4'b1000;
    b4.req = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    pop4 = '0;
    rd4(3, exp_wrap, "wrap3");
    chk("wrap.ovf", int'(ovf4), exp_ovf);
    rd4(2, 7, "keep2");
    rd4(1, 4, "keep1");
    rd4(0, 6, "keep0");
    idle4 = 1'b1;
    tick();
    chk("keep.idle", int'(b4.valid), 0);

    b4.req = 1'b1; b4.idx = 2'd0; idle4 = 1'b0;
    tick();
    chk("pend.valid", int'(b4.valid), 0);
    b4.req = 1'b0; idle4 = 1'b1; reset = 1'b1;
    tick();
    chk("prst.valid", int'(b4.valid), 0);
    chk("prst.cuenta", int'(b4.cuenta), 0);
    chk("prst.ovf", int'(ovf4), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("prst.q%0d", i), int'(b4.valid), 0);
    end
    for (int i = 0; i < 4; i++)
      rd4(i, 0, $sformatf("prst.c%0d", i));
    b4.req = 1'b0;

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) pop8[i] = (i >= k);
      pop3 = (k < 2) ? 3'b100 : 3'b000;
      tick();
    end
    pop8 = '0;
    pop3 = '0;
    for (int k = 0; k < 8; k++) begin
      b8.req = 1'b1;
      b8.idx = 3'(k);
      b3.req = (k < 2);
      b3.idx = (k == 0) ? 2'd2 : 2'd3;
      tick();
      chk($sformatf("b8.%0d.valid", k), int'(b8.valid), 1);
      chk($sformatf("b8.%0d.cuenta", k), int'(b8.cuenta), k + 1);
      if (k == 0) begin
        chk("b3.ch2.valid", int'(b3.valid), 1);
        chk("b3.ch2.cuenta", int'(b3.cuenta), 2);
      end
      if (k == 1) begin
        chk("b3.oor.valid", int'(b3.valid), 1);
        chk("b3.oor.cuenta", int'(b3.cuenta), 0);
      end
    end
    b8.req = 1'b0;
    b3.req = 1'b0;
    tick();
    chk("b8.end.valid", int'(b8.valid), 0);
    chk("b8.end.cuenta", int'(b8.cuenta), 8);
    chk("b8.ovf", int'(ovf8), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pop_counter_bank.md
Name: pop_counter_bank

Overview:
Parametrised per-FIFO pop counter bank for the Etapa2 FIFO subsystem. It generalises the fixed 4-channel, 5-bit pop counter to FIFO_UNITS channels and a CNT_W-bit count width. A read request made while the subsystem is busy is held pending and served once IDLE is asserted. Counts are read out by index through a registered req/valid handshake.

Parameters:
FIFO_UNITS, 4, number of FIFO channels counted; must be ≥ 2.
INDEX, 2, width of idx; INDEX = clog2(FIFO_UNITS).
CNT_W, 5, width of each channel counter and of cuenta.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req  input  1  read request for channel idx.
idx  input  INDEX  channel selected for readout; sampled when req=1.
IDLE  input  1  subsystem idle; reads are served only when IDLE=1.
pop  input  FIFO_UNITS  per-channel pop strobes; bit i increments counter i.
cuenta  output  CNT_W  registered count of the served channel.
valid  output  1  one-cycle pulse qualifying cuenta.
ovf  output  FIFO_UNITS  sticky per-channel overflow flags.

Behaviour:
- Reset: all counters, cuenta, valid and ovf go to 0; FSM goes to S_READY; any pending request is discarded. Reset has priority over every other event.
- Counting: on each clock edge, every counter i with pop[i]=1 increments by 1. All channels count independently and simultaneously.
- Wrap without the macro: a counter at 2^CNT_W-1 wraps to 0; ovf stays 0.
- FSM states: S_READY (nothing pending) and S_PEND (one request captured, waiting for IDLE).
- S_READY, req=1, IDLE=1: at this edge, cuenta <= cnt[idx] and valid <= 1. The FSM stays in S_READY.
- S_READY, req=1, IDLE=0: at this edge, idx is captured into pend_idx and the FSM moves to S_PEND.
- S_PEND, IDLE=1: at this edge, cuenta <= cnt[pend_idx] and valid <= 1; the FSM returns to S_READY.
- S_PEND: req is ignored, so a new request is dropped and not queued.
- Latency: valid is high in the cycle after the serving edge and stays high for exactly one cycle.
- Back-to-back: req may be asserted in the same cycle valid is high, giving one serviced read per cycle when IDLE=1.
- Simultaneous pop and read on the same channel: cuenta reports the pre-increment value; the counter still increments.
- Read-out never modifies counter contents.
- cuenta holds its last value while valid=0.
- idx ≥ FIFO_UNITS (non-power-of-2 FIFO_UNITS): cuenta <= 0, valid still pulses.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
Macro POPCNT_SATURATE_EN.
- Defined: a counter at 2^CNT_W-1 holds that value on further pops, and ovf[i] sets to 1 and stays set until reset.
- Undefined: counters wrap to 0 and ovf is tied to 0.

Decomposition:
- Package pop_counter_pkg holds the FSM state encoding (S_READY=1'b0, S_PEND=1'b1) and a CNT_MAX helper (2^CNT_W-1).
- One sub-module, pop_counter_chan, implements a single counter (clk, reset, pop, count, ovf), saturation included. It is instantiated FIFO_UNITS times through a generate loop.
- Read mux and FSM live in the top module.

Test Plan:
- Reset, then 3 pops on ch0 and 7 pops on ch2; req=1, idx=2, IDLE=1 -> next cycle valid=1 for 1 cycle, cuenta=7.
- IDLE=0, req=1 idx=1 after 4 pops on ch1; IDLE held 0 for 5 cycles, then 1 -> valid pulses the cycle after IDLE rises, cuenta=4. A req with idx=3 issued during S_PEND produces no second valid.
- 33 pops on ch3 (CNT_W=5) -> without macro, readout gives cuenta=1 and ovf=0; with POPCNT_SATURATE_EN, cuenta=31 and ovf[3]=1.
- pop[0]=1 in the same cycle as req idx=0 with count=5 -> cuenta=5; a following read gives 6.
- reset asserted while in S_PEND -> no valid afterwards, all counts 0, cuenta=0.
- FIFO_UNITS=8, INDEX=3, CNT_W=8; distinct pop counts 1..8 on ch0..7; back-to-back reads idx 0..7 with IDLE=1 -> 8 consecutive valid cycles, cuenta=1..8.
